// File: rtl/adc_acq_scheduler.sv
// -----------------------------------------------------------------------------
// adc_acq_scheduler
//
// Schedules burst acquisitions from a multi-channel ADC capture unit and turns
// each accepted frame into a stream of per-channel samples.
//
// A burst starts on acq_start. The capture unit is then enabled and every
// adc_read_done pulse offers one 8-channel frame. A frame is accepted only if
// the serializer can take it; otherwise it is dropped and counted as an
// overrun. The burst ends after frame_count frames (0 = run until aborted) or
// on acq_abort. The block then drains the pending samples and pulses acq_done.
// A watchdog moves the block to ERROR if the capture unit stops producing
// frames.
//
// Ports
//   sys_clk          clock, rising edge
//   rst              asynchronous active-high reset
//   acq_start        one-cycle pulse, begins a burst
//   acq_abort        ends a burst early / leaves ERROR
//   frame_count[15:0] frames per burst, 0 = continuous (sampled on start)
//   chan_mask[7:0]   bit i enables channel i+1 (sampled on start)
//   adc_read_done    one-cycle pulse, adc_ch_data valid in that cycle
//   adc_ch_data[127:0] ch1 at [15:0] ... ch8 at [127:112]
//   adc_enable       conversion enable to the capture unit
//   sample_data[15:0], sample_chan[2:0], sample_valid, sample_ready
//                    serialized sample stream (valid/ready handshake)
//   acq_busy         burst running or draining
//   acq_done         one-cycle pulse when a burst completes normally
//   acq_error        sticky watchdog error flag
//   frames_captured[15:0] frames accepted in the current burst
//   overrun_count[7:0]    frames dropped in the current burst, saturating
// -----------------------------------------------------------------------------
module adc_acq_scheduler #(
  parameter int FPGA_CLOCK_FREQ   = 100,
  parameter int ADC_SAMPLING_RATE = 20,
  parameter int TIMEOUT_CYCLES    = 4 * FPGA_CLOCK_FREQ * 1000 / ADC_SAMPLING_RATE
) (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic         acq_start,
  input  logic         acq_abort,
  input  logic [15:0]  frame_count,
  input  logic [7:0]   chan_mask,
  input  logic         adc_read_done,
  input  logic [127:0] adc_ch_data,
  output logic         adc_enable,
  output logic [15:0]  sample_data,
  output logic [2:0]   sample_chan,
  output logic         sample_valid,
  input  logic         sample_ready,
  output logic         acq_busy,
  output logic         acq_done,
  output logic         acq_error,
  output logic [15:0]  frames_captured,
  output logic [7:0]   overrun_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERROR} state_t;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state;
  logic [15:0]     frame_limit;   // latched frame_count
  logic [7:0]      mask;          // latched chan_mask
  logic [127:0]    shadow;        // frame being serialized
  logic [7:0]      pending;       // channels of the shadow frame not yet sent
  logic [WD_W-1:0] wd_count;      // RUN cycles since entry or last read_done

  logic        handshake;
  logic        last_sample;
  logic        ser_free;
  logic        capture;
  logic        drop;
  logic        start_ok;
  logic [15:0] frames_next;

  // Lowest pending channel is the one on the bus.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    sample_chan = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) sample_chan = 3'(i);
    end
  end

  assign sample_data  = shadow[{sample_chan, 4'h0} +: 16];
  assign sample_valid = |pending;
  assign handshake    = sample_valid & sample_ready;
  // Only one channel left: clearing the lowest bit empties the mask.
  assign last_sample  = (pending & (pending - 8'd1)) == 8'd0;
  assign ser_free     = !sample_valid || (handshake && last_sample);
  assign capture      = (state == RUN) && adc_read_done && ser_free;
  assign drop         = (state == RUN) && adc_read_done && !ser_free;
  assign frames_next  = frames_captured + 16'd1;
  assign start_ok     = acq_start && !acq_abort;

  assign adc_enable   = (state == RUN);
  assign acq_busy     = (state == RUN) || (state == DRAIN);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      // NOTE: the shadow frame is reset along with the control state so no
      // stale sample data from an interrupted burst can appear on sample_data.
      state           <= IDLE;
      frame_limit     <= '0;
      mask            <= '0;
      shadow          <= '0;
      pending         <= '0;
      wd_count        <= '0;
      acq_done        <= 1'b0;
      acq_error       <= 1'b0;
      frames_captured <= '0;
      overrun_count   <= '0;
    end else begin
      acq_done <= 1'b0;

      // Serializer: a new frame replaces the shadow only when it is free;
      // otherwise each handshake retires the lowest pending channel.
      if (capture) begin
        shadow  <= adc_ch_data;
        pending <= mask;
      end else if (handshake) begin
        pending <= pending & (pending - 8'd1);
      end

      if (capture) frames_captured <= frames_next;
      if (drop && overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;

      if ((state == IDLE || state == ERROR) && start_ok) begin
        state           <= RUN;
        frame_limit     <= frame_count;
        mask            <= chan_mask;
        wd_count        <= '0;
        acq_error       <= 1'b0;
        frames_captured <= '0;
        overrun_count   <= '0;
      end else begin
        case (state)
          RUN: begin
            wd_count <= adc_read_done ? '0 : wd_count + 1'b1;
            if (acq_abort ||
                (capture && frame_limit != 16'd0 && frames_next == frame_limit)) begin
              state <= DRAIN;
            end else if (!adc_read_done && wd_count == WD_W'(TIMEOUT_CYCLES - 1)) begin
              state     <= ERROR;
              acq_error <= 1'b1;
              pending   <= '0;  // flush: no samples survive a watchdog error
            end
          end
          DRAIN: begin
            if (!sample_valid) begin
              state    <= IDLE;
              acq_done <= 1'b1;
            end
          end
          ERROR: begin
            if (acq_abort) state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
